// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: strobe edge detect, bin/Gray write pointer,
// read-pointer sync, registered full/level/overflow and optional almost-full.
// Ports: clk, rst_n, i_line, i_rd_ptr_gray -> o_wr_en, o_wr_addr, o_wr_ptr_gray,
// o_full, o_wr_level, o_ovf, o_afull. Option macro: FIFO_WR_AFULL_EN.
module fifo_wr_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_line,
  input  logic [ADDR_W:0]   i_rd_ptr_gray,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W:0]   o_wr_ptr_gray,
  output logic              o_full,
  output logic [ADDR_W:0]   o_wr_level,
  output logic              o_ovf,
  output logic              o_afull
);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic            line_q;
  logic [ADDR_W:0] wr_bin;
  logic [ADDR_W:0] wr_gray;
  logic [ADDR_W:0] rq1;
  logic [ADDR_W:0] rq2;

  logic            req;
  logic            accept;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] full_cmp;
  logic [ADDR_W:0] level_next;

  assign req = i_line & ~line_q;
  // rst_n gate kills an in-flight write the moment reset asserts,
  // since line_q = 0 during reset would otherwise look like a fresh edge.
  assign accept = req & ~o_full & rst_n;
  assign o_wr_en = accept;
  assign o_wr_addr = wr_bin[ADDR_W-1:0];
  assign o_wr_ptr_gray = wr_gray;

  assign wbin_next  = accept ? wr_bin + 1'b1 : wr_bin;
  assign wgray_next = accept ? bin2gray(wr_bin + 1'b1) : wr_gray;
  // Full when write is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp   = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};
  assign level_next = wbin_next - gray2bin(rq2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q     <= 1'b0;
      wr_bin     <= '0;
      wr_gray    <= '0;
      rq1        <= '0;
      rq2        <= '0;
      o_full     <= 1'b0;
      o_wr_level <= '0;
      o_ovf      <= 1'b0;
    end else begin
      line_q     <= i_line;
      wr_bin     <= wbin_next;
      wr_gray    <= wgray_next;
      rq1        <= i_rd_ptr_gray;
      rq2        <= rq1;
      o_full     <= (wgray_next == full_cmp);
      o_wr_level <= level_next;
      o_ovf      <= req & o_full;
    end
  end

`ifdef FIFO_WR_AFULL_EN
  logic afull_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level_next >= (ADDR_W+1)'(AFULL_THRESH));
    end
  end

  assign o_afull = afull_q;
`else
  logic unused_thresh;
  assign unused_thresh = (AFULL_THRESH != 0);
  assign o_afull = 1'b0;
`endif

endmodule
